ft_fifo_chip_side: RTL and testbench

Bus-functional responder for the 16-bit synchronous FIFO bus: it implements the chip side of the TXE_N/RXF_N/OE_N/RD_N/WR_N/DATA/BE interface that the FPGA-side bus controller drives. An RX FIFO holds words waiting to be read by the controller, and a TX FIFO holds words written by it. Each FIFO connects to a valid/ready stream port for the host-side logic or testbench. It is used for loopback testing and as the synthesizable stand-in for the USB bridge chip.

---
 rtl/ft_fifo_chip_side.sv | 125 ++++++++++++
 tb/tb_ft_fifo_chip_side.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ft_fifo_chip_side.sv
// Chip-side responder for the 16-bit synchronous FIFO bus: an RX FIFO read by the
// bus controller and a TX FIFO written by it, each with a host-side valid/ready port.
module ft_fifo_chip_side #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  output logic          RXF_N,
  output logic          TXE_N,
  input  logic          OE_N,
  input  logic          RD_N,
  input  logic          WR_N,
  inout  wire  [15:0]   DATA,
  inout  wire  [1:0]    BE,
  input  logic [15:0]   in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [15:0]   out_data,
  output logic [1:0]    out_be,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   rx_level,
  output logic [AW:0]   tx_level,
  output logic          rd_underrun,
  output logic          wr_overrun,
  output logic          proto_err
);

  localparam int unsigned LW = AW + 1;
  localparam logic [AW:0] FULL_LVL = LW'(DEPTH);

  logic [15:0]   rx_mem [DEPTH];
  logic [17:0]   tx_mem [DEPTH];
  logic [AW-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
  logic [15:0]   dout_reg;
  logic [17:0]   tx_head;

  logic rx_empty, rx_full, tx_empty, tx_full;
  logic bus_rd, bus_wr, bad_wr;
  logic rx_push, rx_pop, tx_push, tx_pop;

  assign rx_empty = (rx_level == '0);
  assign rx_full  = (rx_level == FULL_LVL);
  assign tx_empty = (tx_level == '0);
  assign tx_full  = (tx_level == FULL_LVL);

  assign bus_rd = !OE_N && !RD_N;
  assign bus_wr = !WR_N && OE_N;
  assign bad_wr = !WR_N && !OE_N;

  // Push/pop qualifiers use registered fullness only, so a full FIFO never accepts a push.
  assign rx_push = in_valid && !rx_full;
  assign rx_pop  = bus_rd && !rx_empty;
  assign tx_push = bus_wr && !tx_full;
  assign tx_pop  = out_valid && out_ready;

  assign RXF_N     = rx_empty;
  assign TXE_N     = tx_full;
  assign in_ready  = !rx_full;
  assign out_valid = !tx_empty;

  assign tx_head  = tx_mem[tx_rp];
  assign out_data = tx_head[15:0];
  assign out_be   = tx_head[17:16];

  // Bus turnaround is purely combinational on OE_N.
  assign DATA = OE_N ? 16'hzzzz : dout_reg;
  assign BE   = OE_N ? 2'bzz    : 2'b11;

  always_ff @(posedge CLK) begin
    if (rx_push) rx_mem[rx_wp] <= in_data;
    if (tx_push) tx_mem[tx_wp] <= {BE, DATA};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_level <= '0;
      dout_reg <= 16'h0000;
    end else begin
      if (rx_push) rx_wp <= rx_wp + AW'(1);
      if (rx_pop) begin
        rx_rp    <= rx_rp + AW'(1);
        dout_reg <= rx_mem[rx_rp];
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_level <= rx_level + LW'(1);
        2'b01:   rx_level <= rx_level - LW'(1);
        default: rx_level <= rx_level;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_level <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      case ({tx_push, tx_pop})
        2'b10:   tx_level <= tx_level + LW'(1);
        2'b01:   tx_level <= tx_level - LW'(1);
        default: tx_level <= tx_level;
      endcase
    end
  end

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_underrun <= 1'b0;
      wr_overrun  <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      if (bus_rd && rx_empty) rd_underrun <= 1'b1;
      if (bus_wr && tx_full)  wr_overrun  <= 1'b1;
      if (bad_wr)             proto_err   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ft_fifo_chip_side.sv
// Bench for ft_fifo_chip_side: queue-based reference model checked every cycle,
// directed bus scenarios with literal expectations, then randomized traffic.
module tb_ft_fifo_chip_side;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        RXF_N, TXE_N;
  logic        OE_N, RD_N, WR_N;
  logic [15:0] tb_data;
  logic [1:0]  tb_be;
  wire  [15:0] DATA;
  wire  [1:0]  BE;
  logic [15:0] in_data;
  logic        in_valid, in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_be;
  logic        out_valid, out_ready;
  logic [AW:0] rx_level, tx_level;
  logic        rd_underrun, wr_overrun, proto_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Controller side drives the bus only while it owns the direction.
  assign DATA = OE_N ? tb_data : 16'hzzzz;
  assign BE   = OE_N ? tb_be   : 2'bzz;

  always #5 CLK = ~CLK;

  ft_fifo_chip_side #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK(CLK), .RST_N(RST_N), .RXF_N(RXF_N), .TXE_N(TXE_N),
    .OE_N(OE_N), .RD_N(RD_N), .WR_N(WR_N), .DATA(DATA), .BE(BE),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_be(out_be), .out_valid(out_valid), .out_ready(out_ready),
    .rx_level(rx_level), .tx_level(tx_level),
    .rd_underrun(rd_underrun), .wr_overrun(wr_overrun), .proto_err(proto_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain queues and flags.
  logic [15:0] m_rxq[$];
  logic [17:0] m_txq[$];
  logic [15:0] m_dout = 16'h0000;
  logic        m_under = 1'b0, m_over = 1'b0, m_proto = 1'b0;

  always @(negedge RST_N) begin
    m_rxq.delete();
    m_txq.delete();
    m_dout  = 16'h0000;
    m_under = 1'b0;
    m_over  = 1'b0;
    m_proto = 1'b0;
  end

  always @(posedge CLK) begin
    if (RST_N === 1'b1) begin
      bit rx_was_full, tx_was_full, push_rx, pop_tx, push_tx;
      rx_was_full = (m_rxq.size() == DEPTH);
      tx_was_full = (m_txq.size() == DEPTH);
      push_rx = in_valid && !rx_was_full;
      pop_tx  = (m_txq.size() != 0) && out_ready;
      push_tx = !WR_N && OE_N && !tx_was_full;
      if (!OE_N && !RD_N) begin
        if (m_rxq.size() != 0) m_dout = m_rxq.pop_front();
        else                   m_under = 1'b1;
      end
      if (push_rx) m_rxq.push_back(in_data);
      if (!WR_N && OE_N && tx_was_full) m_over = 1'b1;
      if (!WR_N && !OE_N) m_proto = 1'b1;
      if (pop_tx)  void'(m_txq.pop_front());
      if (push_tx) m_txq.push_back({tb_be, tb_data});
    end
  end

  // Compare process: outputs have settled shortly after each posedge.
  always @(posedge CLK) begin
    #2;
    if (RST_N === 1'b1) begin
      check("rxf_n",       32'(RXF_N),     32'(m_rxq.size() == 0));
      check("txe_n",       32'(TXE_N),     32'(m_txq.size() == DEPTH));
      check("in_ready",    32'(in_ready),  32'(m_rxq.size() != DEPTH));
      check("out_valid",   32'(out_valid), 32'(m_txq.size() != 0));
      check("rx_level",    32'(rx_level),  32'(m_rxq.size()));
      check("tx_level",    32'(tx_level),  32'(m_txq.size()));
      check("rd_underrun", 32'(rd_underrun), 32'(m_under));
      check("wr_overrun",  32'(wr_overrun),  32'(m_over));
      check("proto_err",   32'(proto_err),   32'(m_proto));
      if (m_txq.size() != 0) begin
        check("out_data", 32'(out_data), 32'(m_txq[0][15:0]));
        check("out_be",   32'(out_be),   32'(m_txq[0][17:16]));
      end
      if (!OE_N) begin
        check("data_drive", 32'(DATA), 32'(m_dout));
        check("be_drive",   32'(BE),   32'(2'b11));
      end else begin
        check("data_release", 32'(DATA), 32'(tb_data));
        check("be_release",   32'(BE),   32'(tb_be));
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge CLK);
  endtask

  task automatic idle();
    OE_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic host_push(input logic [15:0] d);
    in_valid = 1'b1; in_data = d;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0;
    idle();
    tb_data = 16'h0; tb_be = 2'b00; in_data = 16'h0;
    cyc(3);
    RST_N = 1'b1;
    cyc();

    // Reset state
    check("rst_rxf_n", 32'(RXF_N), 32'd1);
    check("rst_txe_n", 32'(TXE_N), 32'd0);
    check("rst_rx_level", 32'(rx_level), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Single read
    host_push(16'hA5A5);
    check("push_rx_level", 32'(rx_level), 32'd1);
    check("push_rxf_n", 32'(RXF_N), 32'd0);
    OE_N = 1'b0;
    cyc();
    check("oe_data_reset_val", 32'(DATA), 32'h0000);
    RD_N = 1'b0;
    cyc();
    check("read_data", 32'(DATA), 32'hA5A5);
    check("read_rx_level", 32'(rx_level), 32'd0);
    check("read_rxf_n", 32'(RXF_N), 32'd1);
    idle(); cyc();

    // Burst read then underrun
    host_push(16'd1); host_push(16'd2); host_push(16'd3);
    OE_N = 1'b0; RD_N = 1'b0;
    cyc(); check("burst_1", 32'(DATA), 32'd1);
    cyc(); check("burst_2", 32'(DATA), 32'd2);
    cyc(); check("burst_3", 32'(DATA), 32'd3);
    check("burst_no_underrun", 32'(rd_underrun), 32'd0);
    cyc(); check("underrun_set", 32'(rd_underrun), 32'd1);
    check("underrun_hold", 32'(DATA), 32'd3);
    idle(); cyc();

    // Single write and host drain
    tb_data = 16'h1234; tb_be = 2'b11; WR_N = 1'b0;
    cyc();
    WR_N = 1'b1;
    check("wr_out_valid", 32'(out_valid), 32'd1);
    check("wr_out_data", 32'(out_data), 32'h1234);
    check("wr_out_be", 32'(out_be), 32'd3);
    check("wr_tx_level", 32'(tx_level), 32'd1);
    out_ready = 1'b1;
    cyc();
    out_ready = 1'b0;
    check("drain_out_valid", 32'(out_valid), 32'd0);

    // Fill TX past full, then drain in order
    for (int k = 0; k < 17; k++) begin
      tb_data = 16'(16'h100 + k); tb_be = 2'(k); WR_N = 1'b0;
      cyc();
      if (k == 15) check("full_txe_n", 32'(TXE_N), 32'd1);
    end
    WR_N = 1'b1;
    check("full_overrun", 32'(wr_overrun), 32'd1);
    check("full_tx_level", 32'(tx_level), 32'd16);
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("drain_order", 32'(out_data), 32'(16'h100 + k));
      cyc();
    end
    check("drained_empty", 32'(out_valid), 32'd0);
    // Simultaneous write/drain cycles walk the pointers around
    for (int k = 0; k < 16; k++) begin
      tb_data = 16'(16'h200 + k); tb_be = 2'(~k); WR_N = 1'b0;
      cyc();
    end
    WR_N = 1'b1;
    cyc(2);
    out_ready = 1'b0;

    // Write with OE_N low is a protocol error and is not queued
    OE_N = 1'b0; WR_N = 1'b0;
    cyc();
    idle();
    check("proto_no_push", 32'(tx_level), 32'd0);
    check("proto_err_set", 32'(proto_err), 32'd1);

    // Concurrent host push and bus pop keep the level
    for (int k = 0; k < 5; k++) host_push(16'(16'h300 + k));
    in_valid = 1'b1; in_data = 16'h3FF; OE_N = 1'b0; RD_N = 1'b0;
    cyc();
    in_valid = 1'b0;
    check("simul_level", 32'(rx_level), 32'd5);
    check("simul_data", 32'(DATA), 32'h300);

    // Async reset mid-burst at level 4
    cyc();
    check("pre_reset_level", 32'(rx_level), 32'd4);
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_rx_level", 32'(rx_level), 32'd0);
    check("arst_rxf_n", 32'(RXF_N), 32'd1);
    check("arst_underrun", 32'(rd_underrun), 32'd0);
    check("arst_overrun", 32'(wr_overrun), 32'd0);
    check("arst_proto", 32'(proto_err), 32'd0);
    idle();
    cyc(2);
    RST_N = 1'b1;
    cyc();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      in_valid  = ($urandom_range(0, 99) < 55);
      in_data   = 16'($urandom);
      out_ready = ($urandom_range(0, 99) < 45);
      OE_N      = ($urandom_range(0, 99) < 60);
      RD_N      = ($urandom_range(0, 99) < 50);
      WR_N      = ($urandom_range(0, 99) < 50);
      if (!OE_N && ($urandom_range(0, 99) < 95)) WR_N = 1'b1;
      tb_data   = 16'($urandom);
      tb_be     = 2'($urandom);
      cyc();
    end
    idle();
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
